tenbit_tmds_encoder: RTL and testbench
======================================

// Module: tenbit_tmds_encoder
// PURPOSE
//  Per-lane TMDS 8b/10b encoder, directly downstream of tenbit_phase_gen.
//  Consumes 8-bit fragments (frag_out/de_out/hsync_out/vsync_out/valid) and emits
//  10-bit TMDS symbols with running-disparity DC balance. Outside DE it emits control tokens.
//  One instance per channel; the serializer follows.
// PARAMETERS
//  CHANNEL     0   TMDS lane 0..2; lane 0 carries hsync/vsync, lanes 1/2 carry ctl_in
//  CNT_W       6   signed width of the running-disparity counter
// PORTS
//  clk        in   1   pixel-fragment clock
//  reset      in   1   asynchronous, active-low reset
//  valid_in   in   1   fragment strobe from phase_gen; the pipeline advances only when 1
//  de_in      in   1   data enable (phase_gen de_out)
//  frag_in    in   8   fragment byte (phase_gen frag_out)
//  hsync_in   in   1   control bit c0 on lane 0
//  vsync_in   in   1   control bit c1 on lane 0
//  ctl_in     in   2   {c1,c0} on lanes 1/2; ignored on lane 0
//  tmds_out   out  10  encoded symbol; bit 0 is transmitted first
//  valid_out  out  1   tmds_out updated this cycle
//  de_out     out  1   de aligned with tmds_out
// BEHAVIOUR
//  - Reset (reset==0, async): tmds_out=10'b1101010100 (ctl 00), valid_out=0, de_out=0,
//    disparity cnt=0, all pipeline registers cleared. Release is taken on the next clk edge.
//  - Pipeline: 2 stages, each enabled by valid_in. Latency is 2 valid beats.
//    valid_out is valid_in delayed 2 clk. Stalled beats hold all state, including cnt.
//  - Stage 1 (q_m): N1=popcount(frag_in).
//    Use XNOR chaining if N1>4, or if N1==4 and frag_in[0]==0; otherwise use XOR chaining.
//    q_m[8]=1 for XOR, 0 for XNOR. de, the c bits and q_m are registered.
//  - Stage 2 (de=1): n1/n0 are the ones/zeros of q_m[7:0].
//    * cnt==0 or n1==n0: out={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}.
//      cnt+= q_m[8] ? n1-n0 : n0-n1.
//    * (cnt>0 & n1>n0) | (cnt<0 & n0>n1): out={1,q_m[8],~q_m[7:0]}.
//      cnt+= 2*q_m[8] + n0-n1.
//    * else: out={0,q_m[8],q_m[7:0]}. cnt+= -2*~q_m[8] + n1-n0.
//  - Stage 2 (de=0): cnt<=0. The token is selected by {c1,c0}:
//    00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011.
//  - cnt arithmetic is two's complement in CNT_W bits. By construction |cnt|<=16, so it never wraps.
//  - Fragment phase and packed_p/packed_c are not inputs. The encoder is phase-agnostic:
//    de alone selects data vs control.
//  - A DE transition mid-stream takes effect on the beat it arrives. The first data beat after
//    control starts from cnt=0.
// CONFIGURATION
//  TENBIT_TMDS_GUARD_BAND_EN
//  - Defined:
//    * A 2-beat delay line (valid-gated) is added after stage 2, so latency is 4 valid beats.
//    * When a 0->1 de edge enters the delay line, the 2 control symbols already in it are
//      replaced by the video guard band: lane 0/2 = 10'b1011001100, lane 1 = 10'b0100110011.
//    * A DE edge fewer than 2 beats after the previous DE fall overwrites only the control
//      symbols present; data symbols are never overwritten.
//  - Undefined: no delay line and no override; latency is 2.
// STRUCTURE
//  - Package tenbit_tmds_pkg holds:
//    * localparams CTL_TOKEN_00/01/10/11 and GB_VIDEO_CH0/CH1/CH2;
//    * the CNT_W default;
//    * function popcount8.
//  - Sub-module tenbit_tmds_qm: stage-1 transition minimizer (registered q_m[8:0] plus de/c
//    passthrough, valid-gated).
//  - Top: disparity stage, optional guard-band delay line.
// TESTING
//  1. Reset: hold reset=0 with valid_in=1 -> tmds_out=0x354, valid_out=0.
//     Release -> first valid_out 2 clk after the first valid_in.
//  2. de=1, frag=0x00 x2 starting from cnt=0 -> tmds 0x100 (cnt=-8), then 0x3FF (cnt=+2).
//  3. de=0, CHANNEL=0, {vsync,hsync}=00/01/10/11 -> 0x354/0x0AB/0x154/0x2AB.
//     cnt reads 0 after the first control beat.
//  4. Stall: hold valid_in=0 for 5 clk mid-line with frag changing -> tmds_out/cnt unchanged.
//     The stream resumes identical to the unstalled reference sequence.
//  5. Random 10k frags with de=1 -> decode of every symbol equals its input.
//     |cumulative ones-zeros| over the stream stays <=16.
//  6. GUARD_BAND_EN, CHANNEL=1: control 01, then de rises -> the 2 beats before the first data
//     symbol are 0x133, and the data is unaltered.
//     de rises 1 beat after a fall -> a single 0x133.

Source files
------------

// File: rtl/tenbit_tmds_pkg.sv
// Shared constants and helpers for the per-lane TMDS 8b/10b encoder.
// Guard-band insertion is built only when TENBIT_TMDS_GUARD_BAND_EN is defined.
package tenbit_tmds_pkg;

  localparam logic [9:0] CTL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTL_TOKEN_11 = 10'b1010101011;

  localparam logic [9:0] GB_VIDEO_CH0 = 10'b1011001100;
  localparam logic [9:0] GB_VIDEO_CH1 = 10'b0100110011;
  localparam logic [9:0] GB_VIDEO_CH2 = 10'b1011001100;

  localparam int CNT_W_DEFAULT = 6;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, d[i]};
    return s;
  endfunction

  function automatic logic [9:0] ctl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = CTL_TOKEN_00;
      2'b01:   t = CTL_TOKEN_01;
      2'b10:   t = CTL_TOKEN_10;
      default: t = CTL_TOKEN_11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tenbit_tmds_qm.sv
// Stage 1 of the TMDS encoder: transition-minimised q_m with de/control passthrough,
// registered only on valid beats.
module tenbit_tmds_qm
  import tenbit_tmds_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  logic       de_in,
  input  logic [7:0] frag_in,
  input  logic [1:0] c_in,
  output logic [8:0] q_m,
  output logic       de,
  output logic [1:0] c
);

  // XNOR chaining when the byte is ones-heavy (ties broken by bit 0); q_m[8]=1 marks XOR.
  function automatic logic [8:0] minimize(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_m <= '0;
      de  <= 1'b0;
      c   <= 2'b00;
    end else if (valid_in) begin
      q_m <= minimize(frag_in);
      de  <= de_in;
      c   <= c_in;
    end
  end

endmodule

// File: rtl/tenbit_tmds_encoder.sv
// Per-lane TMDS encoder top: q_m stage, running-disparity stage and, with
// TENBIT_TMDS_GUARD_BAND_EN defined, a 2-beat delay line that inserts the video guard band.
module tenbit_tmds_encoder
  import tenbit_tmds_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  logic       de_in,
  input  logic [7:0] frag_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [1:0] ctl_in,
  output logic [9:0] tmds_out,
  output logic       valid_out,
  output logic       de_out
);

  // Handshake: no back-pressure; every pipeline register advances only on a clk edge with
  // valid_in=1, and valid_out is simply valid_in delayed by the pipeline depth in clocks.

  localparam logic signed [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic signed [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] CNT_EIGHT = CNT_W'(8);

  logic [1:0] c_sel;
  logic [8:0] s1_qm;
  logic       s1_de;
  logic [1:0] s1_c;

  assign c_sel = (CHANNEL == 0) ? {vsync_in, hsync_in} : ctl_in;

  tenbit_tmds_qm u_qm (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .de_in    (de_in),
    .frag_in  (frag_in),
    .c_in     (c_sel),
    .q_m      (s1_qm),
    .de       (s1_de),
    .c        (s1_c)
  );

  logic signed [CNT_W-1:0] n1_s, n0_s, diff_s, cnt_q, cnt_d;
  logic        [9:0]       sym_d, s2_sym;
  logic                    s2_de, q8;

  assign q8     = s1_qm[8];
  assign n1_s   = $signed({{(CNT_W-4){1'b0}}, popcount8(s1_qm[7:0])});
  assign n0_s   = CNT_EIGHT - n1_s;
  assign diff_s = n1_s - n0_s;

  always_comb begin
    sym_d = ctl_token(s1_c);
    cnt_d = cnt_q;
    if (!s1_de) begin
      cnt_d = CNT_ZERO;
    end else if ((cnt_q == CNT_ZERO) || (n1_s == n0_s)) begin
      sym_d = {~q8, q8, q8 ? s1_qm[7:0] : ~s1_qm[7:0]};
      cnt_d = q8 ? (cnt_q + diff_s) : (cnt_q - diff_s);
    end else if (((cnt_q > CNT_ZERO) && (n1_s > n0_s)) || ((cnt_q < CNT_ZERO) && (n0_s > n1_s))) begin
      sym_d = {1'b1, q8, ~s1_qm[7:0]};
      cnt_d = cnt_q - diff_s + (q8 ? CNT_TWO : CNT_ZERO);
    end else begin
      sym_d = {1'b0, q8, s1_qm[7:0]};
      cnt_d = cnt_q + diff_s - (q8 ? CNT_ZERO : CNT_TWO);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_sym <= CTL_TOKEN_00;
      s2_de  <= 1'b0;
      cnt_q  <= CNT_ZERO;
    end else if (valid_in) begin
      s2_sym <= sym_d;
      s2_de  <= s1_de;
      cnt_q  <= cnt_d;
    end
  end

`ifdef TENBIT_TMDS_GUARD_BAND_EN
  localparam int LAT = 4;

  logic [9:0] gb_sym, d1_sym, d2_sym;
  logic       d1_de, d2_de, de_rise;

  assign gb_sym  = (CHANNEL == 1) ? GB_VIDEO_CH1 : ((CHANNEL == 2) ? GB_VIDEO_CH2 : GB_VIDEO_CH0);
  // First data beat is being encoded now; the two symbols ahead of it move into the delay line.
  assign de_rise = s1_de && !s2_de;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d1_sym <= CTL_TOKEN_00;
      d1_de  <= 1'b0;
      d2_sym <= CTL_TOKEN_00;
      d2_de  <= 1'b0;
    end else if (valid_in) begin
      d1_sym <= de_rise ? gb_sym : s2_sym;
      d1_de  <= s2_de;
      d2_sym <= (de_rise && !d1_de) ? gb_sym : d1_sym;
      d2_de  <= d1_de;
    end
  end

  assign tmds_out = d2_sym;
  assign de_out   = d2_de;
`else
  localparam int LAT = 2;

  assign tmds_out = s2_sym;
  assign de_out   = s2_de;
`endif

  logic [LAT-1:0] valid_sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_sr <= '0;
    else        valid_sr <= {valid_sr[LAT-2:0], valid_in};
  end

  assign valid_out = valid_sr[LAT-1];

endmodule

// File: tb/tb_tenbit_tmds_encoder.sv
// Self-checking bench: lanes 0 and 1 driven together, checked against a beat-level TMDS model.
module tb_tenbit_tmds_encoder;

`ifdef TENBIT_TMDS_GUARD_BAND_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid_in = 1'b0;
  logic       de_in = 1'b0;
  logic [7:0] frag_in = '0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [1:0] ctl_in = '0;
  logic [9:0] tmds0, tmds1;
  logic       vout0, vout1, deo0, deo1;

  always #5 clk = ~clk;

  tenbit_tmds_encoder #(.CHANNEL(0)) dut0 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .de_in(de_in), .frag_in(frag_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .ctl_in(ctl_in),
    .tmds_out(tmds0), .valid_out(vout0), .de_out(deo0)
  );

  tenbit_tmds_encoder #(.CHANNEL(1)) dut1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .de_in(de_in), .frag_in(frag_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .ctl_in(ctl_in),
    .tmds_out(tmds1), .valid_out(vout1), .de_out(deo1)
  );

  int n_checks = 0;
  int n_pass = 0;
  int n_beats = 0;
  int mcnt0 = 0;
  int mcnt1 = 0;
  int run_disp = 0;

  logic [9:0] exp0_q[$];
  logic [9:0] exp1_q[$];
  logic       de_q[$];
  logic [7:0] frag_q[$];
  int         cnt0_q[$];
  int         cnt1_q[$];
  logic       vhist_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (beat %0d)", tag, got, exp, n_beats);
  endtask

  // Model: TMDS rules at beat level; disparity tracked as net ones-minus-zeros of each symbol.
  function automatic logic [9:0] ref_encode(input logic [7:0] d, input logic de, input logic [1:0] c,
                                            input int cnt_in, output int cnt_out);
    logic [8:0] q;
    logic [9:0] s;
    int n1, ones;
    if (!de) begin
      cnt_out = 0;
      case (c)
        2'b00:   s = 10'b1101010100;
        2'b01:   s = 10'b0010101011;
        2'b10:   s = 10'b0101010100;
        default: s = 10'b1010101011;
      endcase
      return s;
    end
    n1   = $countones(d);
    q    = '0;
    q[8] = !((n1 > 4) || (n1 == 4 && !d[0]));
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = q[8] ? (q[i-1] ^ d[i]) : !(q[i-1] ^ d[i]);
    ones = $countones(q[7:0]);
    if (cnt_in == 0 || ones == 4) s = {!q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
    else if ((cnt_in > 0 && ones > 4) || (cnt_in < 0 && ones < 4)) s = {1'b1, q[8], ~q[7:0]};
    else s = {1'b0, q[8], q[7:0]};
    cnt_out = cnt_in + 2 * $countones(s) - 10;
    return s;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] s);
    logic [7:0] v, d;
    v    = s[9] ? ~s[7:0] : s[7:0];
    d    = '0;
    d[0] = v[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (v[i] ^ v[i-1]) : !(v[i] ^ v[i-1]);
    return d;
  endfunction

  task automatic model_push(input logic de, input logic [7:0] f, input logic [1:0] c0, input logic [1:0] c1);
    int nc;
    int j;
    exp0_q.push_back(ref_encode(f, de, c0, mcnt0, nc));
    mcnt0 = nc;
    cnt0_q.push_back(mcnt0);
    exp1_q.push_back(ref_encode(f, de, c1, mcnt1, nc));
    mcnt1 = nc;
    cnt1_q.push_back(mcnt1);
    de_q.push_back(de);
    frag_q.push_back(f);
    n_beats++;
    j = n_beats - 1;
`ifdef TENBIT_TMDS_GUARD_BAND_EN
    if (de && j >= 1 && !de_q[j-1]) begin
      for (int k = j - 1; k >= j - 2 && k >= 0; k--) begin
        if (!de_q[k]) begin
          exp0_q[k] = 10'h2CC;
          exp1_q[k] = 10'h133;
        end
      end
    end
`endif
  endtask

  task automatic check_outputs(input logic v);
    int idx, ci, sz;
    logic [9:0] e0, e1;
    logic ed, ev;
    int ec0, ec1, g0, g1;
    idx = n_beats - LAT;
    if (idx >= 0) begin
      e0 = exp0_q[idx]; e1 = exp1_q[idx]; ed = de_q[idx];
    end else begin
      e0 = 10'h354; e1 = 10'h354; ed = 1'b0;
    end
    check_eq("tmds0", tmds0, e0);
    check_eq("tmds1", tmds1, e1);
    check_eq("de_out0", deo0, ed);
    check_eq("de_out1", deo1, ed);
    ci  = n_beats - 2;
    ec0 = (ci >= 0) ? cnt0_q[ci] : 0;
    ec1 = (ci >= 0) ? cnt1_q[ci] : 0;
    g0  = $signed(dut0.cnt_q);
    g1  = $signed(dut1.cnt_q);
    check_eq("cnt0", g0, ec0);
    check_eq("cnt1", g1, ec1);
    sz = vhist_q.size();
    ev = (sz >= LAT) ? vhist_q[sz-LAT] : 1'b0;
    check_eq("valid_out0", vout0, ev);
    check_eq("valid_out1", vout1, ev);
    if (v && idx >= 0) begin
      if (ed) begin
        check_eq("decode0", ref_decode(tmds0), frag_q[idx]);
        run_disp += 2 * $countones(tmds0) - 10;
        check_eq("disparity_bound", (run_disp <= 16 && run_disp >= -16), 1);
      end else begin
        run_disp = 0;
      end
    end
  endtask

  task automatic step(input logic v, input logic de, input logic [7:0] f,
                      input logic [1:0] c0, input logic [1:0] c1);
    valid_in = v;
    de_in    = de;
    frag_in  = f;
    hsync_in = c0[0];
    vsync_in = c0[1];
    ctl_in   = c1;
    @(posedge clk);
    vhist_q.push_back(v);
    if (v) model_push(de, f, c0, c1);
    @(negedge clk);
    check_outputs(v);
  endtask

  function automatic logic [1:0] rc();
    return 2'($urandom_range(0, 3));
  endfunction

  function automatic logic [7:0] rf();
    return 8'($urandom);
  endfunction

  initial begin
    logic cur_de;
    // Reset held with valid_in high: outputs stay at the reset token.
    reset = 1'b0; valid_in = 1'b1; de_in = 1'b0; frag_in = 8'h5A;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_tmds0", tmds0, 10'h354);
      check_eq("rst_tmds1", tmds1, 10'h354);
      check_eq("rst_valid", vout0, 1'b0);
      check_eq("rst_de", deo0, 1'b0);
    end
    reset = 1'b1;

    // Control tokens on both lanes, then two zero bytes from cnt=0.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, rf(), 2'(i), 2'(i));
    step(1'b1, 1'b1, 8'h00, rc(), rc());
    step(1'b1, 1'b1, 8'h00, rc(), rc());
    step(1'b1, 1'b0, rf(), 2'b00, 2'b01);

    // DE edges: long blank, short blanks of 1 and 2 beats.
    repeat (4) step(1'b1, 1'b0, rf(), 2'b01, 2'b01);
    repeat (4) step(1'b1, 1'b1, rf(), 2'b01, 2'b01);
    step(1'b1, 1'b0, rf(), 2'b01, 2'b01);
    repeat (3) step(1'b1, 1'b1, rf(), 2'b01, 2'b01);
    repeat (2) step(1'b1, 1'b0, rf(), 2'b01, 2'b01);
    repeat (2) step(1'b1, 1'b1, rf(), 2'b01, 2'b01);
    repeat (3) step(1'b1, 1'b0, rf(), 2'b10, 2'b01);

    // Mid-line stall with inputs changing.
    repeat (3) step(1'b1, 1'b1, rf(), rc(), rc());
    repeat (5) step(1'b0, 1'($urandom_range(0, 1)), rf(), rc(), rc());
    repeat (3) step(1'b1, 1'b1, rf(), rc(), rc());

    // Long data stream with occasional stalls.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 9) == 0) step(1'b0, 1'($urandom_range(0, 1)), rf(), rc(), rc());
      step(1'b1, 1'b1, rf(), rc(), rc());
    end

    // Mixed data/control runs of random length.
    cur_de = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) cur_de = ~cur_de;
      step(1'($urandom_range(0, 7) != 0), cur_de, rf(), rc(), rc());
    end

    repeat (LAT + 2) step(1'b1, 1'b0, rf(), rc(), rc());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
